int_req_ctrl: RTL and testbench



---
 rtl/int_req_pkg.sv | 23 ++
 rtl/int_req_ctrl_if.sv | 38 +++
 rtl/int_req_ctrl_prio_enc.sv | 22 ++
 rtl/int_req_ctrl.sv | 100 ++++++++++
 tb/tb_int_req_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/int_req_pkg.sv
// Shared definitions for the peripheral-side interrupt requester.
// Holds the FSM state encoding, default parameters and the vector address helper.
// No ports; imported by the interface, encoder and top.
package int_req_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam int          DEF_NUM_SRC         = 4;
  localparam logic [31:0] DEF_VEC_BASE        = 32'h0000_0040;
  localparam int unsigned DEF_VEC_STRIDE_LOG2 = 4;

  // ISR entry address for source idx; wraps modulo 2^32.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input int unsigned stride_log2,
                                           input logic [31:0] idx);
    return base + (idx << stride_log2);
  endfunction

endpackage

// File: rtl/int_req_ctrl_if.sv
// Handshake bundle between peripherals/CPU and the interrupt requester.
// master: the controller (drives interrupt/int_addr/int_id/pending).
// slave: the environment (drives done/status_bit/int_ack/isr_done[/int_mask]).
// Optional INT_REQ_CTRL_MASK_EN adds int_mask.
interface int_req_ctrl_if #(
  parameter int NUM_SRC = int_req_pkg::DEF_NUM_SRC
);
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] done;
  logic               status_bit;
  logic               int_ack;
  logic               isr_done;
`ifdef INT_REQ_CTRL_MASK_EN
  logic [NUM_SRC-1:0] int_mask;
`endif
  logic               interrupt;
  logic [31:0]        int_addr;
  logic [ID_W-1:0]    int_id;
  logic [NUM_SRC-1:0] pending;

  modport master (
`ifdef INT_REQ_CTRL_MASK_EN
    input  int_mask,
`endif
    input  done, status_bit, int_ack, isr_done,
    output interrupt, int_addr, int_id, pending
  );

  modport slave (
`ifdef INT_REQ_CTRL_MASK_EN
    output int_mask,
`endif
    output done, status_bit, int_ack, isr_done,
    input  interrupt, int_addr, int_id, pending
  );

endinterface

// File: rtl/int_req_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
// Latency: purely combinational.
// Backpressure: none; i_req -> o_vld (any set), o_idx (winning index, 0 if none).
module int_prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic          o_vld,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    o_vld = |i_req;
    o_idx = '0;
    // Scan from the top so the lowest set index is written last.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IW'(i);
    end
  end

endmodule

// File: rtl/int_req_ctrl.sv
// Vectored interrupt requester: edge-captures done[] into pending, grants by fixed priority.
// Latency: done rise -> pending next edge -> interrupt the edge after; int_ack drops interrupt at that edge.
// Backpressure: holds one request until int_ack, then blocks new ones until isr_done; no nesting.
// Ports: clk, reset (sync, active-high); bus (int_req_ctrl_if.master) carries the handshake.
// Optional INT_REQ_CTRL_MASK_EN: arbitration uses pending & int_mask (masked sources still latch).
module int_req_ctrl
  import int_req_pkg::*;
#(
  parameter int          NUM_SRC         = DEF_NUM_SRC,
  parameter logic [31:0] VEC_BASE        = DEF_VEC_BASE,
  parameter int unsigned VEC_STRIDE_LOG2 = DEF_VEC_STRIDE_LOG2
) (
  input logic           clk,
  input logic           reset,
  int_req_ctrl_if.master bus
);

  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_e               r_state;
  logic [NUM_SRC-1:0]   r_done_q;
  logic [NUM_SRC-1:0]   r_pending;
  logic                 r_interrupt;
  logic [31:0]          r_int_addr;
  logic [ID_W-1:0]      r_int_id;

  state_e               w_state_nxt;
  logic                 w_grant;
  logic [NUM_SRC-1:0]   w_rise;
  logic [NUM_SRC-1:0]   w_clr;
  logic [NUM_SRC-1:0]   w_arb_req;
  logic                 w_arb_vld;
  logic [ID_W-1:0]      w_arb_idx;

  assign w_rise = bus.done & ~r_done_q;

`ifdef INT_REQ_CTRL_MASK_EN
  assign w_arb_req = r_pending & bus.int_mask;
`else
  assign w_arb_req = r_pending;
`endif

  int_prio_enc #(.N(NUM_SRC), .IW(ID_W)) u_prio (
    .i_req (w_arb_req),
    .o_vld (w_arb_vld),
    .o_idx (w_arb_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_clr       = '0;
    case (r_state)
      IDLE: begin
        if (w_arb_vld && !bus.status_bit) begin
          w_grant     = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        // Request is frozen here: status_bit, mask and newer sources are ignored.
        if (bus.int_ack) begin
          w_clr       = NUM_SRC'(1) << r_int_id;
          w_state_nxt = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.isr_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_done_q    <= '0;
      r_pending   <= '0;
      r_interrupt <= 1'b0;
      r_int_addr  <= '0;
      r_int_id    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_done_q    <= bus.done;
      // Set wins over clear when a rise and an ack hit the same bit.
      r_pending   <= (r_pending & ~w_clr) | w_rise;
      r_interrupt <= (w_state_nxt == REQ);
      if (w_grant) begin
        r_int_id   <= w_arb_idx;
        r_int_addr <= vec_addr(VEC_BASE, VEC_STRIDE_LOG2, 32'(w_arb_idx));
      end
    end
  end

  assign bus.interrupt = r_interrupt;
  assign bus.int_addr  = r_int_addr;
  assign bus.int_id    = r_int_id;
  assign bus.pending   = r_pending;

endmodule

// File: tb/tb_int_req_ctrl.sv
module tb_int_req_ctrl;

  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NS-1:0] mask = '1;

  always #5 clk = ~clk;

  int_req_ctrl_if #(.NUM_SRC(NS)) bus();

  int_req_ctrl #(.NUM_SRC(NS)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

`ifdef INT_REQ_CTRL_MASK_EN
  assign bus.int_mask = mask;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending set plus two flags for "waiting for ack" / "in ISR".
  bit [NS-1:0] m_prev_done;
  bit [NS-1:0] m_pend;
  bit          m_wait_ack;
  bit          m_in_isr;
  int          m_id;
  bit [31:0]   m_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit [NS-1:0] rise;
    bit [NS-1:0] elig;
    if (rst) begin
      m_prev_done = '0; m_pend = '0; m_wait_ack = 0; m_in_isr = 0;
      m_id = 0; m_addr = 32'h0;
      return;
    end
    rise = bus.done & ~m_prev_done;
    m_prev_done = bus.done;
    if (m_wait_ack) begin
      if (bus.int_ack) begin
        m_pend[m_id] = 1'b0;
        m_wait_ack = 0;
        m_in_isr = 1;
      end
    end else if (m_in_isr) begin
      if (bus.isr_done) m_in_isr = 0;
    end else begin
      elig = m_pend & mask;
      if (elig != 0 && !bus.status_bit) begin
        for (int i = 0; i < NS; i++) begin
          if (elig[i]) begin
            m_id = i;
            break;
          end
        end
        m_addr = 32'h40 + 32'(m_id) * 32'd16;
        m_wait_ack = 1;
      end
    end
    m_pend = m_pend | rise;
  endtask

  task automatic cyc(input logic [NS-1:0] d, input logic st, input logic ak, input logic isr);
    bus.done = d; bus.status_bit = st; bus.int_ack = ak; bus.isr_done = isr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("irq",  32'(bus.interrupt), 32'(m_wait_ack));
    check("addr", bus.int_addr, m_addr);
    check("id",   32'(bus.int_id), 32'(m_id));
    check("pend", 32'(bus.pending), 32'(m_pend));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.done = '0; bus.status_bit = 1'b0; bus.int_ack = 1'b0; bus.isr_done = 1'b0;

    // 1: reset, single source, ack clears pending
    rst = 1'b1;
    cyc('0, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("rst_irq", 32'(bus.interrupt), 32'h0);
    check("rst_addr", bus.int_addr, 32'h0);
    check("rst_id", 32'(bus.int_id), 32'h0);
    check("rst_pend", 32'(bus.pending), 32'h0);
    rst = 1'b0;
    cyc(4'b0100, 1'b0, 1'b0, 1'b0);
    check("t1_pend_early", 32'(bus.pending), 32'h4);
    check("t1_irq_early", 32'(bus.interrupt), 32'h0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("t1_irq", 32'(bus.interrupt), 32'h1);
    check("t1_addr", bus.int_addr, 32'h60);
    check("t1_id", 32'(bus.int_id), 32'h2);
    cyc('0, 1'b0, 1'b1, 1'b0);
    check("t1_ack_irq", 32'(bus.interrupt), 32'h0);
    check("t1_ack_pend", 32'(bus.pending), 32'h0);
    cyc('0, 1'b0, 1'b0, 1'b1);

    // 2: simultaneous rises, priority then follow-up after isr_done
    cyc(4'b1010, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("t2_id1", 32'(bus.int_id), 32'h1);
    check("t2_addr1", bus.int_addr, 32'h50);
    cyc('0, 1'b0, 1'b1, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b1);
    check("t2_gap", 32'(bus.interrupt), 32'h0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("t2_id3", 32'(bus.int_id), 32'h3);
    check("t2_addr3", bus.int_addr, 32'h70);
    cyc('0, 1'b0, 1'b1, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b1);

    // 3: status_bit blocks new requests
    cyc(4'b0001, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc('0, 1'b1, 1'b0, 1'b0);
      check("t3_blocked", 32'(bus.interrupt), 32'h0);
    end
    check("t3_pend", 32'(bus.pending), 32'h1);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("t3_irq", 32'(bus.interrupt), 32'h1);
    check("t3_addr", bus.int_addr, 32'h40);
    cyc('0, 1'b0, 1'b1, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b1);

    // 4: rise coincides with ack on the same bit -> set wins
    cyc(4'b0100, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b1, 1'b0);
    check("t4_setwins", 32'(bus.pending), 32'h4);
    cyc('0, 1'b0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("t4_rereq", 32'(bus.interrupt), 32'h1);
    check("t4_reid", 32'(bus.int_id), 32'h2);
    cyc('0, 1'b0, 1'b1, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b1);

    // 5: rise during SERVICE waits for isr_done; ack in SERVICE ignored
    cyc(4'b1000, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b1, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b1, 1'b0);
    cyc('0, 1'b0, 1'b1, 1'b0);
    check("t5_noirq", 32'(bus.interrupt), 32'h0);
    check("t5_pend", 32'(bus.pending), 32'h1);
    check("t5_hold_id", 32'(bus.int_id), 32'h3);
    cyc('0, 1'b0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("t5_id0", 32'(bus.int_id), 32'h0);
    check("t5_addr0", bus.int_addr, 32'h40);
    cyc('0, 1'b0, 1'b1, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b1);

    // 6: reset mid-request abandons it
    cyc(4'b0010, 1'b0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("t6_irq", 32'(bus.interrupt), 32'h0);
    check("t6_pend", 32'(bus.pending), 32'h0);
    rst = 1'b0;
    idle(3);
    check("t6_quiet", 32'(bus.interrupt), 32'h0);

`ifdef INT_REQ_CTRL_MASK_EN
    mask = 4'b1110;
    cyc(4'b0001, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("t6_masked", 32'(bus.interrupt), 32'h0);
    mask = 4'b1111;
    cyc('0, 1'b0, 1'b0, 1'b0);
    check("t6_unmask", 32'(bus.interrupt), 32'h1);
    check("t6_unmask_addr", bus.int_addr, 32'h40);
    cyc('0, 1'b0, 1'b1, 1'b0);
    cyc('0, 1'b0, 1'b0, 1'b1);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [NS-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
`ifdef INT_REQ_CTRL_MASK_EN
      if ($urandom_range(0, 19) == 0) mask = NS'($urandom);
`endif
      rst = ($urandom_range(0, 99) == 0);
      cyc(d, ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 4) == 0));
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
